// File: rtl/ctrl_pkg.sv
// Shared control-unit definitions: memory responder state encoding,
// captured-request record and the load/store opcodes seen by the control FSM.
package ctrl_pkg;

   // Responder FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } resp_state_e;

   // Opcodes the control FSM decodes into MemRead/MemWrite
   localparam logic [5:0] LW = 6'b100011;
   localparam logic [5:0] SW = 6'b101011;

   // Request fields frozen at acceptance; the word index is kept separately
   // because its width follows the memory depth.
   typedef struct packed {
      logic        wr;
      logic        err;
      logic [31:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// Single-port data RAM: synchronous write, registered read. The read register
// only updates on a read enable, so it holds the last successful load.
module mem_array #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage write; contents survive reset
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   // Registered read port, cleared by reset
   always_ff @(posedge clk) begin
      if (reset)   rdata <= '0;
      else if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: accepts one MemRead/MemWrite request at a time,
// waits WAIT_CYCLES, then pulses MemReady (with MemErr for rejected requests).
module data_mem_responder
   import ctrl_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        MemReady,
   output logic        MemErr,
   output logic        Busy
);

   resp_state_e       state;
   logic [3:0]        cnt;
   mem_req_t          cap, live, cur;
   logic [ADDR_W-1:0] cap_idx, live_idx, cur_idx;
   logic              req, go, we, re;

   // Decode the live request; errors are judged on the inputs at acceptance
   always_comb begin
      req        = MemRead | MemWrite;
      live_idx   = Addr[ADDR_W+1:2];
      live.wr    = MemWrite;
      live.wdata = WriteData;
      live.err   = (MemRead & MemWrite) |
                   (Addr[1:0] != 2'b00) |
                   ((Addr >> (ADDR_W + 2)) != 32'd0);
   end

   // Pick the request driving the array and detect the edge that enters RESP.
   // With zero wait states that edge is the acceptance edge itself, so the
   // live inputs are used; otherwise the frozen copy is.
   always_comb begin
      cur     = (state == IDLE) ? live     : cap;
      cur_idx = (state == IDLE) ? live_idx : cap_idx;
      go      = !reset &&
                (((state == IDLE) && req && (WAIT_CYCLES == 0)) ||
                 ((state == WAIT) && (cnt == 4'd1)));
      we      = go &&  cur.wr && !cur.err;
      re      = go && !cur.wr && !cur.err;
   end

   // Responder FSM with registered handshake outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         cap      <= '0;
         cap_idx  <= '0;
         MemReady <= 1'b0;
         MemErr   <= 1'b0;
         Busy     <= 1'b0;
      end else begin
         MemReady <= 1'b0;
         MemErr   <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  cap     <= live;
                  cap_idx <= live_idx;
                  cnt     <= 4'(WAIT_CYCLES);
                  Busy    <= 1'b1;
                  if (WAIT_CYCLES == 0) begin
                     state    <= RESP;
                     MemReady <= 1'b1;
                     MemErr   <= live.err;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               // strobes are ignored here; only the count matters
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state    <= RESP;
                  MemReady <= 1'b1;
                  MemErr   <= cap.err;
               end
            end
            RESP: begin
               state <= IDLE;
               Busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

   mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (32)
   ) u_mem (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .re    (re),
      .addr  (cur_idx),
      .wdata (cur.wdata),
      .rdata (ReadData)
   );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (2 wait states and 0 wait
// states) driven by directed steps and random requests, checked against a
// word-array model of the memory and the request rules.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd    [2];
   logic        wr    [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic [31:0] rdata [2];
   logic        ready [2];
   logic        err   [2];
   logic        busy  [2];

   int checks = 0;
   int errors = 0;

   // model: memory contents and last successful load, per instance
   logic [31:0] mdl    [2][256];
   logic [31:0] exp_rd [2];

   always #5 clk = ~clk;

   // index 0: WAIT_CYCLES=2
   data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut2 (
      .clk(clk), .reset(reset), .MemRead(rd[0]), .MemWrite(wr[0]),
      .Addr(addr[0]), .WriteData(wdata[0]), .ReadData(rdata[0]),
      .MemReady(ready[0]), .MemErr(err[0]), .Busy(busy[0]));

   // index 1: WAIT_CYCLES=0
   data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .MemRead(rd[1]), .MemWrite(wr[1]),
      .Addr(addr[1]), .WriteData(wdata[1]), .ReadData(rdata[1]),
      .MemReady(ready[1]), .MemErr(err[1]), .Busy(busy[1]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One request on instance d: strobe before an edge, hold until MemReady,
   // drop in the MemReady cycle. Optional perturbation scrambles Addr,
   // WriteData and MemRead while the request is in flight.
   task automatic xact(input int d, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] wd, input bit perturb, input string tag);
      int   n;
      bit   got;
      bit   e;
      int   lat;
      logic [7:0] idx;
      lat = (d == 0) ? 3 : 1;
      e   = (r && w) || (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
      idx = a[9:2];
      @(negedge clk);
      rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd;
      @(posedge clk);
      n = 0; got = 0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         if (ready[d]) got = 1;
         else begin
            check({tag, ".busy_wait"}, 32'(busy[d]), 32'd1);
            if (perturb) begin
               addr[d]  = $urandom;
               wdata[d] = $urandom;
               rd[d]    = ~rd[d];
            end
         end
      end
      rd[d] = 1'b0; wr[d] = 1'b0;
      if (!e) begin
         if (w) mdl[d][idx] = wd;
         else   exp_rd[d]   = mdl[d][idx];
      end
      check({tag, ".latency"}, 32'(n), 32'(lat));
      check({tag, ".err"}, 32'(err[d]), 32'(e));
      check({tag, ".busy_resp"}, 32'(busy[d]), 32'd1);
      check({tag, ".rdata"}, rdata[d], exp_rd[d]);
      @(negedge clk);
      check({tag, ".ready_drop"}, 32'(ready[d]), 32'd0);
      check({tag, ".busy_idle"}, 32'(busy[d]), 32'd0);
   endtask

   task automatic check_idle_outputs(input string tag);
      for (int d = 0; d < 2; d++) begin
         check({tag, ".rdata"}, rdata[d], 32'd0);
         check({tag, ".ready"}, 32'(ready[d]), 32'd0);
         check({tag, ".err"}, 32'(err[d]), 32'd0);
         check({tag, ".busy"}, 32'(busy[d]), 32'd0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int          op, kind;
      reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         rd[d] = 0; wr[d] = 0; addr[d] = 0; wdata[d] = 0; exp_rd[d] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_idle_outputs("reset");

      // basic write/read
      xact(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, "wr10");
      xact(0, 1, 0, 32'h10, 32'h0, 0, "rd10");
      check("rd10.value", rdata[0], 32'hDEADBEEF);

      // misaligned and out-of-range reads keep ReadData
      xact(0, 1, 0, 32'h12, 32'h0, 0, "rd_misal");
      xact(0, 1, 0, 32'h400, 32'h0, 0, "rd_oob");
      check("rd_oob.kept", rdata[0], 32'hDEADBEEF);

      // both strobes high: rejected, no write
      xact(0, 0, 1, 32'h20, 32'h5, 0, "wr20");
      xact(0, 1, 1, 32'h20, 32'h77, 0, "both20");
      xact(0, 1, 0, 32'h20, 32'h0, 0, "rd20");
      check("rd20.value", rdata[0], 32'h5);

      // inputs scrambled during WAIT: captured values win
      xact(0, 0, 1, 32'h40, 32'hA5A5_5A5A, 1, "wr40_pert");
      xact(0, 1, 0, 32'h40, 32'h0, 1, "rd40_pert");
      check("rd40.value", rdata[0], 32'hA5A5_5A5A);

      // reset during WAIT aborts the write
      xact(0, 0, 1, 32'h30, 32'h1, 0, "wr30");
      @(negedge clk);
      wr[0] = 1; addr[0] = 32'h30; wdata[0] = 32'h99;
      @(posedge clk);
      @(negedge clk);
      check("abort.busy", 32'(busy[0]), 32'd1);
      reset = 1'b1; wr[0] = 0;
      @(negedge clk);
      reset = 1'b0;
      exp_rd[0] = 0; exp_rd[1] = 0;
      check_idle_outputs("after_reset");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort.no_ready", 32'(ready[0]), 32'd0);
      end
      xact(0, 1, 0, 32'h30, 32'h0, 0, "rd30");
      check("rd30.value", rdata[0], 32'h1);

      // zero wait states
      xact(1, 0, 1, 32'h8, 32'h1234_5678, 0, "w0_wr8");
      xact(1, 1, 0, 32'h8, 32'h0, 0, "w0_rd8");
      @(negedge clk);
      rd[1] = 1; addr[1] = 32'h8;
      @(posedge clk);
      @(negedge clk);
      check("b2b.first_ready", 32'(ready[1]), 32'd1);
      check("b2b.first_data", rdata[1], 32'h1234_5678);
      @(negedge clk);
      check("b2b.gap", 32'(ready[1]), 32'd0);
      @(negedge clk);
      check("b2b.second_ready", 32'(ready[1]), 32'd1);
      check("b2b.second_err", 32'(err[1]), 32'd0);
      rd[1] = 0;
      @(negedge clk);
      check("b2b.done", 32'(ready[1]), 32'd0);

      // random traffic over a prefilled window
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 16; i++)
            xact(d, 0, 1, 32'h80 + 32'(4 * i), $urandom, 0, "prefill");
         for (int i = 0; i < 30; i++) begin
            op   = $urandom_range(0, 9);
            kind = $urandom_range(0, 9);
            a    = 32'h80 + 32'(4 * $urandom_range(0, 15));
            if (kind == 8) a = a | 32'($urandom_range(1, 3));
            if (kind == 9) a = a | (32'($urandom_range(1, 1023)) << 10);
            xact(d, (op <= 3) || (op >= 8), (op >= 4) && (op <= 8), a, $urandom,
                 (d == 0) && ($urandom_range(0, 1) == 1), "rand");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
